// File: rtl/pmp_dispatcher.sv
// pmp_dispatcher: host-side feeder for the pattern-matching modules (PMM).
// Each module has its own request FIFO and a 3-state handshake FSM that
// drives the PMM data/control/valid inputs with a 4-phase valid/ready
// exchange. PMM accept pulses are collected into sticky match flags.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   S_IDLE    | nothing presented; load the FIFO head when one exists
//   S_DRIVE   | DATA_VALID high, waiting for READY_STATUS or timeout
//   S_RELEASE | DATA_VALID low, waiting for the PMM to drop READY_STATUS
module pmp_dispatcher #(
    parameter int NO_MODULES     = 4,
    parameter int DATA_W         = 64,
    parameter int CTRL_W         = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [1:0]                   IN_MODULE,
    input  logic [DATA_W-1:0]            IN_DATA,
    input  logic [CTRL_W-1:0]            IN_CONTROL,
    output logic [NO_MODULES*DATA_W-1:0] PMM_DATA,
    output logic [NO_MODULES*CTRL_W-1:0] PMM_CONTROL,
    output logic [NO_MODULES-1:0]        PMM_DATA_VALID,
    input  logic [NO_MODULES-1:0]        PMM_READY_STATUS,
    input  logic [NO_MODULES-1:0]        PMM_ACCEPTED_STATUS,
    input  logic [NO_MODULES-1:0]        MATCH_CLEAR,
    output logic [NO_MODULES-1:0]        MATCH_STATUS,
    output logic [NO_MODULES-1:0]        TIMEOUT_ERR,
    output logic [NO_MODULES-1:0]        BUSY
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMR_W   = (TMR_RAW > 8) ? TMR_RAW : 8;
    localparam int ENT_W   = DATA_W + CTRL_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    logic [NO_MODULES-1:0] full;

    // Ready reflects the start-of-cycle occupancy only, so a pop never frees
    // a slot for a push in the same cycle.
    assign IN_READY = ~full[IN_MODULE];

    for (genvar i = 0; i < NO_MODULES; i++) begin : g_mod
        logic [ENT_W-1:0]  mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        state_t            state;
        logic [TMR_W-1:0]  timer;
        logic [DATA_W-1:0] data_q;
        logic [CTRL_W-1:0] ctrl_q;
        logic              valid_q;
        logic              terr_q;
        logic              push;
        logic              pop;
        logic              expired;

        assign push    = IN_VALID && IN_READY && (IN_MODULE == 2'(i));
        assign expired = (timer >= TMR_W'(TIMEOUT_CYCLES));
        assign pop     = (state == S_DRIVE) && (PMM_READY_STATUS[i] || expired);
        assign full[i] = (count == CNT_W'(FIFO_DEPTH));

        // Request storage; contents are don't-care while the entry is empty.
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= {IN_DATA, IN_CONTROL};
        end

        // FIFO pointers and occupancy count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Handshake FSM with registered PMM outputs and timeout timer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= S_IDLE;
                timer   <= '0;
                data_q  <= '0;
                ctrl_q  <= '0;
                valid_q <= 1'b0;
                terr_q  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (count != '0) begin
                            data_q  <= mem[rd_ptr][ENT_W-1:CTRL_W];
                            ctrl_q  <= mem[rd_ptr][CTRL_W-1:0];
                            valid_q <= 1'b1;
                            timer   <= '0;
                            state   <= S_DRIVE;
                        end
                    end
                    S_DRIVE: begin
                        if (PMM_READY_STATUS[i]) begin
                            valid_q <= 1'b0;
                            state   <= S_RELEASE;
                        end else if (expired) begin
                            terr_q  <= 1'b1;
                            valid_q <= 1'b0;
                            state   <= S_RELEASE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        if (!PMM_READY_STATUS[i]) state <= S_IDLE;
                    end
                    default: begin
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end

        assign PMM_DATA[i*DATA_W +: DATA_W]    = data_q;
        assign PMM_CONTROL[i*CTRL_W +: CTRL_W] = ctrl_q;
        assign PMM_DATA_VALID[i]               = valid_q;
        assign TIMEOUT_ERR[i]                  = terr_q;
        assign BUSY[i]                         = (count != '0) || (state != S_IDLE);
    end

    // Sticky match flags; a new accept pulse outranks a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) MATCH_STATUS <= '0;
        else        MATCH_STATUS <= (MATCH_STATUS & ~MATCH_CLEAR) | PMM_ACCEPTED_STATUS;
    end

endmodule

// File: tb/tb_pmp_dispatcher.sv
// Testbench for pmp_dispatcher: directed scenarios plus a randomized phase.
// Accepted requests go into per-module expected queues; a negedge monitor
// pops and compares whenever a PMM sees a new DATA_VALID rising edge.
module tb_pmp_dispatcher;
    localparam int NM    = 4;
    localparam int DW    = 64;
    localparam int CW    = 16;
    localparam int DEPTH = 4;
    localparam int TO    = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              IN_VALID = 1'b0;
    logic              IN_READY;
    logic [1:0]        IN_MODULE = '0;
    logic [DW-1:0]     IN_DATA = '0;
    logic [CW-1:0]     IN_CONTROL = '0;
    logic [NM*DW-1:0]  PMM_DATA;
    logic [NM*CW-1:0]  PMM_CONTROL;
    logic [NM-1:0]     PMM_DATA_VALID;
    logic [NM-1:0]     PMM_READY_STATUS;
    logic [NM-1:0]     PMM_ACCEPTED_STATUS = '0;
    logic [NM-1:0]     MATCH_CLEAR = '0;
    logic [NM-1:0]     MATCH_STATUS;
    logic [NM-1:0]     TIMEOUT_ERR;
    logic [NM-1:0]     BUSY;

    logic [NM-1:0] auto_en = '0;
    logic [NM-1:0] auto_ready = '0;
    logic [NM-1:0] man_ready = '0;
    assign PMM_READY_STATUS = (auto_en & auto_ready) | (~auto_en & man_ready);

    int n_pass = 0;
    int n_total = 0;
    bit chk_rdy = 1'b0;

    logic [DW+CW-1:0] exp_q [NM][$];
    int               mcnt [NM];
    logic [NM-1:0]    mmodel;
    logic [NM-1:0]    prev_v;

    pmp_dispatcher #(
        .NO_MODULES(NM), .DATA_W(DW), .CTRL_W(CW),
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_MODULE(IN_MODULE),
        .IN_DATA(IN_DATA), .IN_CONTROL(IN_CONTROL),
        .PMM_DATA(PMM_DATA), .PMM_CONTROL(PMM_CONTROL),
        .PMM_DATA_VALID(PMM_DATA_VALID), .PMM_READY_STATUS(PMM_READY_STATUS),
        .PMM_ACCEPTED_STATUS(PMM_ACCEPTED_STATUS), .MATCH_CLEAR(MATCH_CLEAR),
        .MATCH_STATUS(MATCH_STATUS), .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: match-flag model, in-order data check, ready model.
    initial begin
        mmodel = '0;
        prev_v = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int m = 0; m < NM; m++) begin
                    exp_q[m].delete();
                    mcnt[m] = 0;
                end
                mmodel = '0;
                prev_v = '0;
            end else begin
                chk("match_status", MATCH_STATUS, mmodel);
                mmodel = (mmodel & ~MATCH_CLEAR) | PMM_ACCEPTED_STATUS;
                for (int m = 0; m < NM; m++) begin
                    if (PMM_DATA_VALID[m] && !prev_v[m]) begin
                        if (exp_q[m].size() == 0) begin
                            chk($sformatf("unexpected_issue_m%0d", m), 1, 0);
                        end else begin
                            logic [DW+CW-1:0] e;
                            e = exp_q[m].pop_front();
                            chk($sformatf("pmm_word_m%0d", m),
                                {PMM_DATA[m*DW +: DW], PMM_CONTROL[m*CW +: CW]}, e);
                        end
                    end
                end
                prev_v = PMM_DATA_VALID;
                if (chk_rdy) chk("in_ready_model", IN_READY, mcnt[IN_MODULE] < DEPTH);
                if (IN_VALID && IN_READY) begin
                    exp_q[IN_MODULE].push_back({IN_DATA, IN_CONTROL});
                    mcnt[IN_MODULE]++;
                end
                for (int m = 0; m < NM; m++)
                    if (PMM_DATA_VALID[m] && PMM_READY_STATUS[m] && mcnt[m] > 0) mcnt[m]--;
            end
        end
    end

    // Randomized PMM responder for modules in auto mode.
    initial begin
        int dly [NM];
        int hold [NM];
        for (int m = 0; m < NM; m++) begin
            dly[m] = $urandom_range(0, 3);
            hold[m] = 0;
        end
        forever begin
            tick();
            for (int m = 0; m < NM; m++) begin
                if (!auto_en[m]) begin
                    auto_ready[m] = 1'b0;
                end else if (!auto_ready[m]) begin
                    if (PMM_DATA_VALID[m]) begin
                        if (dly[m] == 0) begin
                            auto_ready[m] = 1'b1;
                            hold[m] = $urandom_range(0, 2);
                        end else dly[m]--;
                    end
                end else begin
                    if (hold[m] == 0) begin
                        auto_ready[m] = 1'b0;
                        dly[m] = $urandom_range(0, 3);
                    end else hold[m]--;
                end
            end
        end
    end

    task automatic push1(input int m, input logic [DW-1:0] d, input logic [CW-1:0] c);
        IN_VALID = 1'b1; IN_MODULE = 2'(m); IN_DATA = d; IN_CONTROL = c;
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic drain(input string name);
        int left;
        left = 0;
        for (int k = 0; k < 3000; k++) begin
            left = 0;
            for (int m = 0; m < NM; m++) left += exp_q[m].size();
            if (BUSY == '0 && left == 0) break;
            tick();
        end
        chk({name, "_busy"}, BUSY, '0);
        chk({name, "_pending"}, left, 0);
    endtask

    task automatic do_reset();
        IN_VALID = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int len, rises_other;
        bit dropped;
        logic [NM-1:0] pv;

        // 1. reset state with IN_VALID asserted, then a single request
        IN_VALID = 1'b1; IN_MODULE = 2'd2; IN_DATA = '1; IN_CONTROL = '1;
        repeat (3) tick();
        chk("rst_valid", PMM_DATA_VALID, '0);
        chk("rst_data", PMM_DATA, '0);
        chk("rst_ctrl", PMM_CONTROL, '0);
        chk("rst_match", MATCH_STATUS, '0);
        chk("rst_terr", TIMEOUT_ERR, '0);
        chk("rst_busy", BUSY, '0);
        chk("rst_in_ready", IN_READY, 1'b1);
        IN_VALID = 1'b0;
        rst_n = 1'b1;
        tick();
        push1(2, 64'hDEADBEEF_00000001, 16'h0003);
        chk("t1_not_yet", PMM_DATA_VALID, 4'b0000);
        tick();
        chk("t1_valid", PMM_DATA_VALID, 4'b0100);
        chk("t1_data", PMM_DATA[2*DW +: DW], 64'hDEADBEEF_00000001);
        chk("t1_ctrl", PMM_CONTROL[2*CW +: CW], 16'h0003);
        man_ready[2] = 1'b1;
        tick();
        chk("t1_valid_drop", PMM_DATA_VALID, 4'b0000);
        man_ready[2] = 1'b0;
        tick();
        chk("t1_busy", BUSY[2], 1'b0);
        chk("t1_data_hold", PMM_DATA[2*DW +: DW], 64'hDEADBEEF_00000001);

        // 2. fill module 0 while its PMM stalls; fifth request must wait
        auto_en = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            chk("t2_ready_fill", IN_READY, 1'b1);
            push1(0, 64'h1000 + 64'(k), 16'(k));
        end
        IN_VALID = 1'b1; IN_MODULE = 2'd0; IN_DATA = 64'h1004; IN_CONTROL = 16'h4;
        chk("t2_full_stall", IN_READY, 1'b0);
        tick();
        chk("t2_full_stall2", IN_READY, 1'b0);
        man_ready[0] = 1'b1;
        chk("t2_pop_cycle", IN_READY, 1'b0);
        tick();
        chk("t2_after_pop", IN_READY, 1'b1);
        man_ready[0] = 1'b0;
        tick();
        IN_VALID = 1'b0;
        auto_en[0] = 1'b1;
        drain("t2");

        // 3. module 1 never answers; others keep trading under random traffic
        auto_en = 4'b1101;
        man_ready = '0;
        push1(1, 64'hAAAA_0001, 16'hA1);
        push1(1, 64'hAAAA_0002, 16'hA2);
        len = 0; dropped = 1'b0; rises_other = 0; pv = PMM_DATA_VALID;
        for (int k = 0; k < 400; k++) begin
            int sel;
            sel = $urandom_range(0, 2);
            IN_VALID = $urandom_range(0, 1) == 1;
            IN_MODULE = (sel == 0) ? 2'd0 : 2'(sel + 1);
            IN_DATA = {$urandom, $urandom};
            IN_CONTROL = 16'($urandom);
            tick();
            if (!dropped) begin
                if (PMM_DATA_VALID[1]) len++;
                else if (len > 0) begin
                    dropped = 1'b1;
                    chk("t3_terr", TIMEOUT_ERR, 4'b0010);
                end
            end
            for (int m = 0; m < NM; m++)
                if (m != 1 && PMM_DATA_VALID[m] && !pv[m]) rises_other++;
            pv = PMM_DATA_VALID;
        end
        IN_VALID = 1'b0;
        chk("t3_dropped", dropped, 1'b1);
        chk("t3_len_ok", (len >= TO) && (len <= TO + 1), 1'b1);
        chk("t3_next_driven", PMM_DATA_VALID[1], 1'b1);
        chk("t3_others_progress", rises_other >= 10, 1'b1);
        auto_en = 4'b1111;
        drain("t3");
        chk("t3_terr_sticky", TIMEOUT_ERR, 4'b0010);

        // 4. sticky match flag with set-over-clear priority
        PMM_ACCEPTED_STATUS[3] = 1'b1;
        tick();
        PMM_ACCEPTED_STATUS[3] = 1'b0;
        chk("t4_set", MATCH_STATUS[3], 1'b1);
        tick();
        chk("t4_hold", MATCH_STATUS[3], 1'b1);
        PMM_ACCEPTED_STATUS[3] = 1'b1; MATCH_CLEAR[3] = 1'b1;
        tick();
        PMM_ACCEPTED_STATUS[3] = 1'b0;
        chk("t4_set_wins", MATCH_STATUS[3], 1'b1);
        tick();
        MATCH_CLEAR[3] = 1'b0;
        chk("t4_clear", MATCH_STATUS[3], 1'b0);

        // 5. ready held high blocks re-issue; reset mid-drive
        auto_en = 4'b1100;
        man_ready = '0;
        push1(0, 64'h5555_0001, 16'h51);
        tick();
        chk("t5_valid0", PMM_DATA_VALID[0], 1'b1);
        man_ready[0] = 1'b1;
        push1(0, 64'h5555_0002, 16'h52);
        chk("t5_drop0", PMM_DATA_VALID[0], 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_no_reissue", PMM_DATA_VALID[0], 1'b0);
        end
        man_ready[0] = 1'b0;
        tick();
        tick();
        chk("t5_reissue", PMM_DATA_VALID[0], 1'b1);
        push1(1, 64'h6666_0001, 16'h61);
        tick();
        chk("t5_valid1", PMM_DATA_VALID[1], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", PMM_DATA_VALID, '0);
        chk("t5_rst_busy", BUSY, '0);
        chk("t5_rst_terr", TIMEOUT_ERR, '0);
        chk("t5_rst_ready", IN_READY, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        // randomized traffic with ready model, then drain
        auto_en = 4'b1111;
        do_reset();
        chk_rdy = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            IN_VALID = $urandom_range(0, 2) != 0;
            IN_MODULE = 2'($urandom_range(0, 3));
            IN_DATA = {$urandom, $urandom};
            IN_CONTROL = 16'($urandom);
            PMM_ACCEPTED_STATUS = 4'($urandom & $urandom);
            MATCH_CLEAR = 4'($urandom & $urandom);
            tick();
        end
        IN_VALID = 1'b0;
        PMM_ACCEPTED_STATUS = '0;
        MATCH_CLEAR = '0;
        drain("rand");
        chk("rand_terr", TIMEOUT_ERR, '0);
        chk_rdy = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
